// File: rtl/if_fetch.sv
// Instruction fetch unit: owns the program counter, keeps at most one imem fetch
// in flight and presents {pc, instruction, valid} to the if_id register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_jump_en,
  input  logic [31:0] i_jump_addr,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_pc_addr,
  output logic [31:0] o_inst_data
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        drop, drop_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] buf_inst, buf_inst_nxt;
  logic        valid_nxt;
  logic [31:0] pc_addr_nxt;
  logic [31:0] inst_nxt;
  logic        slot_free;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  assign o_imem_req  = (state == S_REQ) && !i_reset;
  assign o_imem_addr = word_align(pc);
  assign slot_free   = !o_valid || !i_stall;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    drop_nxt     = drop;
    buf_pc_nxt   = buf_pc;
    buf_inst_nxt = buf_inst;
    valid_nxt    = o_valid;
    pc_addr_nxt  = o_pc_addr;
    inst_nxt     = o_inst_data;

    // A consumed slot empties unless something below reloads it this edge.
    if (o_valid && !i_stall) begin
      valid_nxt = 1'b0;
      inst_nxt  = NOP_INST;
    end

    case (state)
      S_REQ: state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_imem_rvalid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = S_REQ;
          end else if (slot_free) begin
            valid_nxt   = 1'b1;
            pc_addr_nxt = pc;
            inst_nxt    = i_imem_rdata;
            pc_nxt      = pc + 32'd4;
            state_nxt   = S_REQ;
          end else begin
            buf_pc_nxt   = pc;
            buf_inst_nxt = i_imem_rdata;
            pc_nxt       = pc + 32'd4;
            state_nxt    = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (slot_free) begin
          valid_nxt   = 1'b1;
          pc_addr_nxt = buf_pc;
          inst_nxt    = buf_inst;
          state_nxt   = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase

    // Redirect flushes the slot and buffer; a fetch still in flight is marked
    // for discard so its stale word never reaches the output.
    if (i_jump_en) begin
      pc_nxt       = word_align(i_jump_addr);
      valid_nxt    = 1'b0;
      pc_addr_nxt  = o_pc_addr;
      inst_nxt     = NOP_INST;
      buf_pc_nxt   = buf_pc;
      buf_inst_nxt = buf_inst;
      if (state == S_REQ || (state == S_WAIT && !i_imem_rvalid)) begin
        state_nxt = S_WAIT;
        drop_nxt  = 1'b1;
      end else begin
        state_nxt = S_REQ;
        drop_nxt  = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_REQ;
      pc          <= word_align(RESET_PC);
      drop        <= 1'b0;
      buf_pc      <= 32'd0;
      buf_inst    <= 32'd0;
      o_valid     <= 1'b0;
      o_pc_addr   <= 32'd0;
      o_inst_data <= NOP_INST;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      drop        <= drop_nxt;
      buf_pc      <= buf_pc_nxt;
      buf_inst    <= buf_inst_nxt;
      o_valid     <= valid_nxt;
      o_pc_addr   <= pc_addr_nxt;
      o_inst_data <= inst_nxt;
    end
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit: the producer side of the if_id → id path. It owns the program counter, issues one word fetch at a time to instruction memory, and presents `{pc, instruction, valid}` to the if_id register. It honours the downstream stall and the pc redirect from ex (jumps and taken branches), and discards any stale in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_0000: pc of the first fetch after reset; low 2 bits are ignored.
- `NOP_INST`, default 32'h0000_0013: value driven on `o_inst_data` when not valid (addi x0,x0,0).
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_reset` in 1: reset, synchronous, active-high.
- `i_stall` in 1: downstream cannot accept; hold the output.
- `i_jump_en` in 1: redirect request from ex.
- `i_jump_addr` in 32 (`InstAddrBus`): redirect target.
- `o_imem_req` out 1: fetch request, high for exactly one cycle per fetch.
- `o_imem_addr` out 32: fetch address, word aligned.
- `i_imem_rvalid` in 1: response valid. Arrives ≥1 cycle after the request; at most one request is outstanding.
- `i_imem_rdata` in 32 (`InstDataBus`): fetched word, sampled when `i_imem_rvalid` is high.
- `o_valid` out 1: output slot holds a live instruction.
- `o_pc_addr` out 32: pc of the presented instruction.
- `o_inst_data` out 32: the presented instruction.

## Operation
- Registers:
  - `pc`: next fetch address.
  - state: REQ, WAIT or FULL.
  - `drop` flag.
  - one-entry buffer: `buf_pc`, `buf_inst`.
  - output slot: `o_valid`, `o_pc_addr`, `o_inst_data`.
- Comb outputs: `o_imem_req` = (state == REQ) and not `i_reset`; `o_imem_addr` = `{pc[31:2], 2'b00}`.
- The slot is free at an edge when `o_valid` = 0 or `i_stall` = 0.
- The slot is consumed at any edge with `o_valid` = 1 and `i_stall` = 0. If nothing new loads at that edge, `o_valid` ← 0 and `o_inst_data` ← `NOP_INST`.
- REQ → WAIT unconditionally.
- WAIT, `i_imem_rvalid` = 0: stay in WAIT.
- WAIT, `i_imem_rvalid` = 1:
  - `drop` = 1: discard the data, clear `drop`, → REQ. `pc` is unchanged (it already holds the target).
  - slot free: load the slot with `(pc, i_imem_rdata, 1)`, `pc` ← `pc+4`, → REQ.
  - slot busy: buffer ← `(pc, rdata)`, `pc` ← `pc+4`, → FULL.
- FULL: when the slot is free, load the slot from the buffer, → REQ. Otherwise hold.
- Redirect (`i_jump_en` = 1) has priority over all rules above except reset:
  - `pc` ← `{i_jump_addr[31:2], 2'b00}`.
  - `o_valid` ← 0, `o_inst_data` ← `NOP_INST`; the buffer is invalidated.
  - REQ (a request is going out this cycle) → WAIT with `drop` = 1.
  - WAIT, no rvalid → stay in WAIT, `drop` = 1.
  - WAIT with rvalid → discard the data, → REQ, `drop` = 0.
  - FULL → REQ.
  - A redirect while stalled still flushes the slot.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values:
  - state REQ, `pc` = `RESET_PC` aligned, `drop` = 0, buffer 0.
  - `o_valid` = 0, `o_pc_addr` = 0, `o_inst_data` = `NOP_INST`.
  - `o_imem_req` = 0 while `i_reset` is high.
- Reset asserted mid-fetch: the outstanding response is ignored, because the state returns to REQ and any rvalid seen while in REQ is ignored. Memory must not answer a pre-reset request after reset deasserts.
- Cycle 0 = first cycle with `i_reset` low: `o_imem_req` = 1, `o_imem_addr` = `RESET_PC`.
- With 1-cycle memory (rvalid in cycle 1), `o_valid` = 1 in cycle 2. Steady state is one instruction per 2 cycles; each extra cycle of memory latency adds one cycle.
- Redirect sampled in cycle n: the request for the target is issued in cycle n+1, or in the cycle after the stale response returns.
- A stalled output holds all three output signals stable.
- At most one instruction is buffered, so there is no loss under any stall length.

## Test plan
- Reset sequencing: `RESET_PC` = 0x100, 1-cycle memory returning `addr^0xA5A5_0000`, no stall.
  - Expect requests at 0x100, 0x104, 0x108 in cycles 0, 2, 4.
  - Expect `o_valid` in cycles 2, 4, 6 with matching pc and data.
- Stall with buffering: assert `i_stall` for 6 cycles starting when pc 0x104 is valid.
  - Output holds 0x104; 0x108 goes to FULL; no request is issued while in FULL.
  - After release: 0x104 is consumed, then 0x108 is presented.
- Redirect during WAIT: 3-cycle memory, `i_jump_en` with 0x200 one cycle after the request for 0x10C.
  - The 0x10C response is dropped.
  - The next request is 0x200; the next valid output is pc 0x200.
- Redirect edge cases:
  - Redirect in the rvalid cycle: that data is never presented.
  - Redirect while FULL and stalled: `o_valid` → 0 next cycle, then 0x300 is fetched.
  - Misaligned target 0x303 → fetch at 0x300.
- Wrap and mid-operation reset:
  - `RESET_PC` = 0xFFFF_FFFC: the second fetch is at 0x0000_0000.
  - Reset pulsed while in WAIT: all outputs return to their reset values and fetch restarts at `RESET_PC`.
